// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state type and chunk-count helper for the sequential subtractor
package adder_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_state_e;
   function automatic int nchunk(input int width, input int chunk_w);
      return width / chunk_w;
   endfunction
endpackage

// File: rtl/subtractor_chunk.sv
// subtractor_chunk: combinational CHUNK_W-bit ripple-borrow subtractor slice
module subtractor_chunk #(
   parameter int CHUNK_W = 8
) (
   input  logic [CHUNK_W-1:0] a_i,
   input  logic [CHUNK_W-1:0] b_i,
   input  logic               bin_i,
   output logic [CHUNK_W-1:0] d_o,
   output logic               bout_o,
   output logic               bmsb_o
);
   logic [CHUNK_W:0] br;
   always_comb begin
      br = '0;
      d_o = '0;
      br[0] = bin_i;
      for (int i = 0; i < CHUNK_W; i++) begin
         d_o[i] = a_i[i] ^ b_i[i] ^ br[i];
         br[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & br[i]);
      end
   end
   assign bout_o = br[CHUNK_W];
   assign bmsb_o = br[CHUNK_W-1];
endmodule

// File: rtl/subtractor_32bit_seq.sv
// subtractor_32bit_seq: multi-cycle ripple-borrow subtractor, CHUNK_W bits per clock, valid/ready on both sides
// Define SUB_OVF_EN to add the registered signed-overflow output ovf_o.
module subtractor_32bit_seq
   import adder_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int CHUNK_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   input  logic             bin_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] DIFF_o,
   output logic             bout_o
`ifdef SUB_OVF_EN
   ,
   output logic             ovf_o
`endif
);
   localparam int NCHUNK = nchunk(WIDTH, CHUNK_W);
   localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   if (WIDTH % CHUNK_W != 0) begin : g_bad_chunk
      $error("WIDTH must be a multiple of CHUNK_W");
   end
   sub_state_e state, next_state;
   logic [IW-1:0] idx;
   logic [BW-1:0] base;
   logic [WIDTH-1:0] a_q, b_q;
   logic borrow, last;
   logic [CHUNK_W-1:0] a_c, b_c, d_c;
   logic bo_c;
`ifdef SUB_OVF_EN
   logic bmsb_c;
`else
   logic bmsb_unused;
`endif
   assign base = BW'(int'(idx) * CHUNK_W);
   assign last = idx == IW'(NCHUNK - 1);
   assign a_c  = a_q[base +: CHUNK_W];
   assign b_c  = b_q[base +: CHUNK_W];
   subtractor_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
      .a_i    (a_c),
      .b_i    (b_c),
      .bin_i  (borrow),
      .d_o    (d_c),
      .bout_o (bo_c),
`ifdef SUB_OVF_EN
      .bmsb_o (bmsb_c)
`else
      .bmsb_o (bmsb_unused)
`endif
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else state <= next_state;
   end
   always_comb begin
      next_state = (state == IDLE) ? (valid_i ? BUSY : IDLE) :
                   (state == BUSY) ? (last ? DONE : BUSY) :
                   (ready_i ? IDLE : DONE);
   end
   always_comb begin
      ready_o = (state == IDLE) && !rst_i;
      valid_o = state == DONE;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx <= '0;
         borrow <= 1'b0;
         DIFF_o <= '0;
         bout_o <= 1'b0;
`ifdef SUB_OVF_EN
         ovf_o <= 1'b0;
`endif
      end else if (state == IDLE && valid_i) begin
         a_q <= A_i;
         b_q <= B_i;
         idx <= '0;
         borrow <= bin_i;
      end else if (state == BUSY) begin
         DIFF_o[base +: CHUNK_W] <= d_c;
         borrow <= bo_c;
         idx <= idx + IW'(1);
         if (last) bout_o <= bo_c;
`ifdef SUB_OVF_EN
         if (last) ovf_o <= bmsb_c ^ bo_c;
`endif
      end
   end
endmodule

// File: tb/tb_subtractor_32bit_seq.sv
// tb_subtractor_32bit_seq: directed and randomized checks of subtractor_32bit_seq at CHUNK_W = 8, 1 and 32
module tb_subtractor_32bit_seq;
   logic clk, rst;
   logic vld[3], rdy_o[3], rdy_i[3], bin[3], vo[3], bo[3];
   logic [31:0] a[3], b[3], d[3];
`ifdef SUB_OVF_EN
   logic ov[3];
`endif
   int n_cmp = 0;
   int n_bad = 0;
   function automatic int cw(input int g);
      return g == 0 ? 8 : (g == 1 ? 1 : 32);
   endfunction
   for (genvar g = 0; g < 3; g++) begin : u
      subtractor_32bit_seq #(.WIDTH(32), .CHUNK_W(cw(g))) dut (
         .clk_i   (clk),
         .rst_i   (rst),
         .valid_i (vld[g]),
         .ready_o (rdy_o[g]),
         .A_i     (a[g]),
         .B_i     (b[g]),
         .bin_i   (bin[g]),
         .valid_o (vo[g]),
         .ready_i (rdy_i[g]),
         .DIFF_o  (d[g]),
         .bout_o  (bo[g])
`ifdef SUB_OVF_EN
         ,
         .ovf_o   (ov[g])
`endif
      );
   end
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // returns {borrow_out, signed_overflow, difference} from plain integer arithmetic
   function automatic logic [33:0] ref_sub(input logic [31:0] x, input logic [31:0] y, input logic c);
      longint u = longint'(x) - longint'(y) - longint'(c);
      longint s = longint'($signed(x)) - longint'($signed(y)) - longint'(c);
      logic ovf = (s < -64'sd2147483648) || (s > 64'sd2147483647);
      return {u < 0, ovf, u[31:0]};
   endfunction
   function automatic logic [31:0] pick();
      int sel = $urandom_range(0, 7);
      return sel == 0 ? 32'h0 : sel == 1 ? 32'hFFFF_FFFF : sel == 2 ? 32'h8000_0000 :
             sel == 3 ? 32'h7FFF_FFFF : 32'($urandom);
   endfunction
   task automatic start(input int k, input logic [31:0] x, input logic [31:0] y, input logic c);
      chk("ready_before_accept", rdy_o[k], 1);
      a[k] = x;
      b[k] = y;
      bin[k] = c;
      vld[k] = 1'b1;
      tick;
      vld[k] = 1'b0;
      a[k] = 32'($urandom);
      b[k] = 32'($urandom);
      bin[k] = 1'($urandom);
   endtask
   task automatic wait_done(input int k, output int n);
      n = 0;
      while (!vo[k] && n < 200) begin
         tick;
         n++;
      end
   endtask
   task automatic check_res(input int k, input string tag, input logic [31:0] x, input logic [31:0] y, input logic c);
      logic [33:0] r = ref_sub(x, y, c);
      chk({tag, "_diff"}, d[k], r[31:0]);
      chk({tag, "_bout"}, bo[k], r[33]);
`ifdef SUB_OVF_EN
      chk({tag, "_ovf"}, ov[k], r[32]);
`endif
   endtask
   task automatic run_op(input int k, input string tag, input logic [31:0] x, input logic [31:0] y, input logic c);
      int n;
      rdy_i[k] = 1'b1;
      start(k, x, y, c);
      wait_done(k, n);
      chk({tag, "_latency"}, n, 32 / cw(k));
      check_res(k, tag, x, y, c);
      tick;
      chk({tag, "_valid_after_hs"}, vo[k], 0);
   endtask
   initial begin
      int n;
      logic [33:0] r;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         vld[k] = 1'b0;
         rdy_i[k] = 1'b1;
         a[k] = '0;
         b[k] = '0;
         bin[k] = 1'b0;
      end
      tick;
      chk("ready_in_reset", rdy_o[0], 0);
      tick;
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_valid", vo[k], 0);
         chk("rst_ready", rdy_o[k], 1);
         chk("rst_diff", d[k], 0);
         chk("rst_bout", bo[k], 0);
`ifdef SUB_OVF_EN
         chk("rst_ovf", ov[k], 0);
`endif
      end
      run_op(0, "basic", 32'h0000_0005, 32'h0000_0003, 1'b0);
      run_op(0, "wrap", 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
      run_op(0, "xchunk", 32'h0000_0100, 32'h0000_0001, 1'b0);
      run_op(0, "ovf_pos", 32'h8000_0000, 32'h0000_0001, 1'b0);
      run_op(0, "ovf_neg", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      rdy_i[0] = 1'b0;
      start(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
      wait_done(0, n);
      chk("bp_latency", n, 4);
      r = ref_sub(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
      for (int i = 0; i < 10; i++) begin
         vld[0] = i[0];
         a[0] = 32'($urandom);
         tick;
         chk("bp_diff", d[0], r[31:0]);
         chk("bp_bout", bo[0], r[33]);
         chk("bp_valid", vo[0], 1);
         chk("bp_ready", rdy_o[0], 0);
      end
      vld[0] = 1'b0;
      rdy_i[0] = 1'b1;
      tick;
      chk("bp_hs_valid", vo[0], 0);
      chk("bp_hs_ready", rdy_o[0], 1);
      start(0, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      #1;
      chk("abort_valid", vo[0], 0);
      chk("abort_ready", rdy_o[0], 1);
      chk("abort_diff", d[0], 0);
      wait_done(0, n);
      chk("abort_no_result", vo[0], 0);
      run_op(0, "after_abort", 32'hCAFE_F00D, 32'hCAFE_F00E, 1'b0);
      for (int i = 0; i < 1500; i++) run_op(0, "rnd8", pick(), pick(), 1'($urandom));
      for (int i = 0; i < 800; i++) run_op(1, "rnd1", pick(), pick(), 1'($urandom));
      for (int i = 0; i < 2000; i++) run_op(2, "rnd32", pick(), pick(), 1'($urandom));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
